// File: rtl/pwm_pkg.sv
// Shared constants and FSM state encoding for the PWM frame generator and decoder.
package pwm_pkg;

  localparam int unsigned CHANNELS = 8;
  localparam int unsigned WINDOW   = 100;
  localparam int unsigned CW       = 7;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_frame_deser.sv
// Serial-to-parallel frame capture: shift register, latch-relative bit counter and
// SYNC/RUN framing FSM. Strobes are combinational and qualified by the latch cycle.
module pwm_frame_deser #(
  parameter int unsigned CHANNELS = pwm_pkg::CHANNELS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_in,
  input  logic                latch,
  output logic [CHANNELS-1:0] frame_c,
  output logic                good_c,
  output logic                err_c
);
  import pwm_pkg::*;

  localparam int unsigned      CNTW     = $clog2(2 * CHANNELS);
  localparam logic [CNTW-1:0]  CNT_MAX  = CNTW'(2 * CHANNELS - 1);
  localparam logic [CNTW-1:0]  CNT_FULL = CNTW'(CHANNELS);

  logic [CHANNELS-1:0] shift_q;
  logic [CNTW-1:0]     cnt_q;
  state_t              state_q;

  // Latch-cycle sample opens the next frame, so the counter reloads to 1 there.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      state_q <= SYNC;
    end else begin
      shift_q <= CHANNELS'({shift_q, s_in});
      if (latch) begin
        cnt_q   <= CNTW'(1);
        state_q <= RUN;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  always_comb begin
    frame_c = shift_q;
    good_c  = latch && (state_q == RUN) && (cnt_q == CNT_FULL);
    err_c   = latch && (state_q == RUN) && (cnt_q != CNT_FULL);
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Deserializes latched PWM frames and publishes per-channel high-frame counts
// once every WINDOW good frames; malformed frames restart the window.
module pwm_duty_decoder #(
  parameter int unsigned CHANNELS = pwm_pkg::CHANNELS,
  parameter int unsigned WINDOW   = pwm_pkg::WINDOW,
  parameter int unsigned CW       = pwm_pkg::CW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_in,
  input  logic                   latch,
  output logic [CHANNELS-1:0]    frame_q,
  output logic                   q_valid,
  output logic [CHANNELS*CW-1:0] duty_out,
  output logic                   duty_valid,
  output logic                   frame_err
);

  localparam int unsigned     WCW      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WCW-1:0]  WIN_LAST = WCW'(WINDOW - 1);

  logic [CHANNELS-1:0] frame_c;
  logic                good_c;
  logic                err_c;
  logic                win_done_c;
  logic [CW-1:0]       acc_q [CHANNELS];
  logic [WCW-1:0]      win_q;

  pwm_frame_deser #(
    .CHANNELS (CHANNELS)
  ) u_deser (
    .clk     (clk),
    .reset   (reset),
    .s_in    (s_in),
    .latch   (latch),
    .frame_c (frame_c),
    .good_c  (good_c),
    .err_c   (err_c)
  );

  assign win_done_c = good_c && (win_q == WIN_LAST);

  // The closing frame's bits are folded directly into the published counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q    <= '0;
      q_valid    <= 1'b0;
      duty_out   <= '0;
      duty_valid <= 1'b0;
      frame_err  <= 1'b0;
      win_q      <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      q_valid    <= good_c;
      frame_err  <= err_c;
      duty_valid <= win_done_c;
      if (good_c) begin
        frame_q <= frame_c;
      end
      if (err_c) begin
        win_q <= '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          acc_q[c] <= '0;
        end
      end else if (win_done_c) begin
        win_q <= '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          duty_out[c*CW +: CW] <= acc_q[c] + CW'(frame_c[c]);
          acc_q[c]             <= '0;
        end
      end else if (good_c) begin
        win_q <= win_q + WCW'(1);
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          acc_q[c] <= acc_q[c] + CW'(frame_c[c]);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: framing table, duty windows, error and reset cases.
module tb_pwm_duty_decoder;

  localparam int unsigned CH  = 8;
  localparam int unsigned CW  = 7;
  localparam int unsigned WIN = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_in;
  logic             latch;
  logic [CH-1:0]    frame_q;
  logic             q_valid;
  logic [CH*CW-1:0] duty_out;
  logic             duty_valid;
  logic             frame_err;

  int errors = 0;
  int checks = 0;

  pwm_duty_decoder #(
    .CHANNELS (CH),
    .WINDOW   (WIN),
    .CW       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_in       (s_in),
    .latch      (latch),
    .frame_q    (frame_q),
    .q_valid    (q_valid),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [15:0] bits;
    logic        exp_qv;
    logic        exp_err;
    logic [7:0]  exp_fq;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic l);
    @(negedge clk);
    s_in  = s;
    latch = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk(name, 64'({q_valid, frame_err, duty_valid}), 64'(0));
  endtask

  // First step carries the latch (closing the previous frame) and f[7].
  task automatic send_frame(input logic [7:0] f, output logic qv, output logic err,
                            output logic dv, output logic [7:0] fq);
    step(f[7], 1'b1);
    qv  = q_valid;
    err = frame_err;
    dv  = duty_valid;
    fq  = frame_q;
    for (int i = 6; i >= 0; i--) begin
      step(f[i], 1'b0);
      chk_idle("pulse_idle");
    end
  endtask

  function automatic logic [7:0] pat(input int k, input int mode);
    logic [7:0] p;
    for (int c = 0; c < 8; c++) p[c] = (mode == 1) ? 1'b1 : (k < 10 * (c + 1));
    return p;
  endfunction

  task automatic window(input int mode, input logic [7:0] tail,
                        output int n_qv, output int n_dv, output int dv_at, output int n_err,
                        output logic dv_with_qv, output logic first_qv,
                        output logic first_err, output logic [7:0] first_fq);
    logic qv, err, dv;
    logic [7:0] fq;
    n_qv = 0; n_dv = 0; dv_at = -1; n_err = 0; dv_with_qv = 1'b1;
    first_qv = 1'b0; first_err = 1'b0; first_fq = '0;
    for (int k = 0; k <= 100; k++) begin
      send_frame((k < 100) ? pat(k, mode) : tail, qv, err, dv, fq);
      if (k == 0) begin
        first_qv = qv; first_err = err; first_fq = fq;
      end else begin
        if (qv) n_qv++;
        if (err) n_err++;
      end
      if (dv) begin
        n_dv++;
        dv_at = k;
        if (!qv) dv_with_qv = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_in  = 1'b1;
    latch = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_frame_q", 64'(frame_q), 64'(0));
    chk("rst_duty_out", 64'(duty_out), 64'(0));
    chk("rst_pulses", 64'({q_valid, frame_err, duty_valid}), 64'(0));
    @(posedge clk);
    #1;
    chk("rst_hold_pulses", 64'({q_valid, frame_err, duty_valid}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    s_in  = 1'b0;
    latch = 1'b0;
  endtask

  task automatic chk_duty(input string name, input int mode);
    for (int c = 0; c < 8; c++) begin
      chk(name, 64'(duty_out[c*CW +: CW]), 64'((mode == 1) ? 100 : 10 * (c + 1)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n_qv, n_dv, dv_at, n_err;
    logic dv_with_qv, fqv, ferr, qv, err, dv;
    logic [7:0] ffq, fq;

    tbl[0] = '{8,  16'h00A5, 1'b0, 1'b0, 8'h00};  // sync latch
    tbl[1] = '{8,  16'h003C, 1'b1, 1'b0, 8'hA5};
    tbl[2] = '{5,  16'h0016, 1'b1, 1'b0, 8'h3C};
    tbl[3] = '{8,  16'h00FF, 1'b0, 1'b1, 8'h3C};  // closes 5-bit frame
    tbl[4] = '{1,  16'h0001, 1'b1, 1'b0, 8'hFF};
    tbl[5] = '{8,  16'h0081, 1'b0, 1'b1, 8'hFF};  // back-to-back latch
    tbl[6] = '{8,  16'h0000, 1'b1, 1'b0, 8'h81};
    tbl[7] = '{8,  16'h005A, 1'b1, 1'b0, 8'h00};
    tbl[8] = '{1,  16'h0000, 1'b1, 1'b0, 8'h5A};

    reset = 1'b1;
    s_in  = 1'b0;
    latch = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_frame_q", 64'(frame_q), 64'(0));
    chk("init_duty_out", 64'(duty_out), 64'(0));
    chk("init_pulses", 64'({q_valid, frame_err, duty_valid}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    for (int r = 0; r < 9; r++) begin
      for (int i = 0; i < tbl[r].n; i++) begin
        step(tbl[r].bits[tbl[r].n - 1 - i], (i == 0));
        if (i == 0) begin
          chk("tbl_q_valid", 64'(q_valid), 64'(tbl[r].exp_qv));
          chk("tbl_frame_err", 64'(frame_err), 64'(tbl[r].exp_err));
          chk("tbl_frame_q", 64'(frame_q), 64'(tbl[r].exp_fq));
          chk("tbl_duty_valid", 64'(duty_valid), 64'(0));
        end else begin
          chk_idle("tbl_idle");
        end
      end
    end

    // Staircase duty window
    do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    window(0, 8'hC3, n_qv, n_dv, dv_at, n_err, dv_with_qv, fqv, ferr, ffq);
    chk("win0_sync_qv", 64'(fqv), 64'(0));
    chk("win0_sync_err", 64'(ferr), 64'(0));
    chk("win0_n_qv", 64'(n_qv), 64'(100));
    chk("win0_n_err", 64'(n_err), 64'(0));
    chk("win0_n_dv", 64'(n_dv), 64'(1));
    chk("win0_dv_at", 64'(dv_at), 64'(100));
    chk("win0_dv_with_qv", 64'(dv_with_qv), 64'(1));
    chk("win0_frame_q", 64'(frame_q), 64'(8'h00));
    chk_duty("win0_duty", 0);

    // Short frame after one good frame, then an all-ones window
    step(1'b1, 1'b1);
    chk("short_pre_qv", 64'(q_valid), 64'(1));
    chk("short_pre_fq", 64'(frame_q), 64'(8'hC3));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk_idle("short_idle");
    end
    window(1, 8'h5A, n_qv, n_dv, dv_at, n_err, dv_with_qv, fqv, ferr, ffq);
    chk("short_err", 64'(ferr), 64'(1));
    chk("short_qv", 64'(fqv), 64'(0));
    chk("short_fq_held", 64'(ffq), 64'(8'hC3));
    chk("win1_n_qv", 64'(n_qv), 64'(100));
    chk("win1_n_dv", 64'(n_dv), 64'(1));
    chk("win1_dv_at", 64'(dv_at), 64'(100));
    chk("win1_dv_with_qv", 64'(dv_with_qv), 64'(1));
    chk_duty("win1_duty", 1);

    // Missing latch: 20 samples since last latch saturates the counter
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      chk_idle("miss_idle");
    end
    send_frame(8'h3C, qv, err, dv, fq);
    chk("miss_err", 64'(err), 64'(1));
    chk("miss_qv", 64'(qv), 64'(0));
    chk("miss_fq_held", 64'(fq), 64'(8'hFF));
    send_frame(8'h11, qv, err, dv, fq);
    chk("after_miss_qv", 64'(qv), 64'(1));
    chk("after_miss_err", 64'(err), 64'(0));
    chk("after_miss_fq", 64'(fq), 64'(8'h3C));

    // Reset in mid-window discards the partial accumulation
    for (int k = 0; k < 50; k++) begin
      send_frame(8'hFF, qv, err, dv, fq);
      chk("mid_no_dv", 64'(dv), 64'(0));
    end
    do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    window(1, 8'h00, n_qv, n_dv, dv_at, n_err, dv_with_qv, fqv, ferr, ffq);
    chk("win2_sync_qv", 64'(fqv), 64'(0));
    chk("win2_sync_err", 64'(ferr), 64'(0));
    chk("win2_n_qv", 64'(n_qv), 64'(100));
    chk("win2_n_dv", 64'(n_dv), 64'(1));
    chk("win2_dv_at", 64'(dv_at), 64'(100));
    chk("win2_dv_with_qv", 64'(dv_with_qv), 64'(1));
    chk_duty("win2_duty", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
